ode_bu_row_scheduler: RTL



---
 rtl/ode_bu_row_scheduler.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ode_bu_row_scheduler.sv
// Row scheduler for h*(B.U): one shared saturating fixed-point multiplier,
// time-multiplexed between the per-row dot product and the final h scale.
module ode_bu_row_scheduler #(
  parameter int M    = 3,
  parameter int N    = 2,
  parameter int FRAC = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       h,
  input  logic [16*M-1:0]   U,
  input  logic [16*N*M-1:0] B,
  output logic [15:0]       out_data,
  output logic [15:0]       out_row,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int KW = (M > 1) ? $clog2(M) : 1;
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam logic signed [31:0] P_MAX = 32'sd32767;
  localparam logic signed [31:0] P_MIN = -32'sd32768;

  typedef enum logic [2:0] {IDLE, MAC, SCALE, OUT, FIN} state_t;

  state_t                state_q, state_d;
  logic signed [15:0]    h_q, h_d;
  logic signed [15:0]    u_q [M];
  logic signed [15:0]    u_d [M];
  logic signed [15:0]    b_q [N][M];
  logic signed [15:0]    b_d [N][M];
  logic signed [15:0]    acc_q, acc_d;
  logic [KW-1:0]         k_q, k_d;
  logic [RW-1:0]         r_q, r_d;
  logic [15:0]           out_data_q, out_data_d;
  logic [15:0]           out_row_q, out_row_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic signed [15:0]    mul_a, mul_b, mul_res;
  logic signed [31:0]    prod, prod_sh;
  logic                  mul_ovf;
  logic [16:0]           sum;
  logic [15:0]           add_res;
  logic                  add_ovf;

  // Shared multiplier: dot-product operands in MAC, acc*h in SCALE; saturating
  logic [16*N*M-1:0] unused_ok;
  always_comb begin
    unused_ok = B;
    mul_a = b_q[r_q][k_q];
    mul_b = u_q[k_q];
    if (state_q == SCALE) begin
      mul_a = acc_q;
      mul_b = h_q;
    end
    prod    = mul_a * mul_b;
    prod_sh = prod >>> FRAC;
    mul_ovf = 1'b0;
    mul_res = prod_sh[15:0];
    if (prod_sh > P_MAX) begin
      mul_res = 16'sh7FFF;
      mul_ovf = 1'b1;
    end else if (prod_sh < P_MIN) begin
      mul_res = -16'sh8000;
      mul_ovf = 1'b1;
    end
  end

  // Saturating accumulate: 17-bit sum, clamp when the top two bits disagree
  always_comb begin
    sum     = {acc_q[15], acc_q} + {mul_res[15], mul_res};
    add_ovf = sum[16] ^ sum[15];
    add_res = add_ovf ? (sum[16] ? 16'h8000 : 16'h7FFF) : sum[15:0];
  end

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    u_d         = u_q;
    b_d         = b_q;
    acc_d       = acc_q;
    k_d         = k_q;
    r_d         = r_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    err_d       = err_q;
    case (state_q)
      IDLE: if (start) begin
        h_d = h;
        for (int k = 0; k < M; k++) u_d[k] = U[16*(M-k)-1 -: 16];
        for (int r = 0; r < N; r++)
          for (int k = 0; k < M; k++) b_d[r][k] = B[16*(N*M-(r*M+k))-1 -: 16];
        r_d     = '0;
        k_d     = '0;
        acc_d   = '0;
        err_d   = 1'b0;
        state_d = MAC;
      end
      MAC: begin
        acc_d = add_res;
        if (mul_ovf || add_ovf) err_d = 1'b1;
        if (k_q == KW'(M-1)) state_d = SCALE;
        else k_d = k_q + KW'(1);
      end
      SCALE: begin
        out_data_d  = mul_res;
        out_row_d   = 16'(r_q);
        out_valid_d = 1'b1;
        if (mul_ovf) err_d = 1'b1;
        state_d     = OUT;
      end
      OUT: if (out_ready) begin
        out_valid_d = 1'b0;
        if (r_q == RW'(N-1)) begin
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          r_d     = r_q + RW'(1);
          k_d     = '0;
          acc_d   = '0;
          state_d = MAC;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers, synchronous reset has priority
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      h_q         <= '0;
      for (int k = 0; k < M; k++) u_q[k] <= '0;
      for (int r = 0; r < N; r++)
        for (int k = 0; k < M; k++) b_q[r][k] <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      r_q         <= '0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      u_q         <= u_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      r_q         <= r_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = err_q;

endmodule
